// File: rtl/serial_operand_tx.sv
// Parallel-to-serial operand transmitter: captures two WIDTH-bit operands
// and shifts them out LSB-first to the serial adder datapath.
//
// Ports:
//   clock       system clock, rising-edge active
//   reset       asynchronous active-low reset
//   load        capture a_in/b_in (only when ready=1)
//   hold        pause shifting while in SHIFT
//   a_in, b_in  parallel operands
//   ready       high in IDLE only
//   shift_cont  high while a valid bit pair is presented
//   s_input_A   serial bit of operand A
//   s_input     serial bit of operand B
//   done        one-cycle pulse after the last bit pair
module serial_operand_tx #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             hold,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             shift_cont,
    output logic             s_input_A,
    output logic             s_input,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            cnt        <= '0;
            shift_cont <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        a_sr       <= a_in;
                        b_sr       <= b_in;
                        cnt        <= '0;
                        state      <= SHIFT;
                        shift_cont <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!hold) begin
                        // Zero fill leaves both lines low after the last bit.
                        a_sr <= a_sr >> 1;
                        b_sr <= b_sr >> 1;
                        if (cnt == LAST) begin
                            state      <= DONE;
                            shift_cont <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            cnt        <= cnt + 1'b1;
                            shift_cont <= 1'b1;
                        end
                    end else begin
                        shift_cont <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    shift_cont <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign s_input_A = a_sr[0];
    assign s_input   = b_sr[0];

endmodule

// File: tb/tb_serial_operand_tx.sv
// Testbench for serial_operand_tx: directed scenarios plus random traffic,
// checked each cycle against a bit-index reference model.
module tb_serial_operand_tx;

    logic       clock;
    logic       reset;
    logic       load4, hold4, load8, hold8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       ready4, sc4, sa4, sb4, done4;
    logic       ready8, sc8, sa8, sb8, done8;

    int tests = 0;
    int fails = 0;

    // reference model: operand plus number of bits already consumed
    int         mode [2];
    logic [7:0] aop  [2];
    logic [7:0] bop  [2];
    int         idx  [2];
    logic       sc   [2];
    int         wid  [2];

    // observed serial streams (bits seen while shift_cont=1)
    logic [31:0] col_a4, col_b4, col_a8;
    int          n4, n8, d4, d8;

    serial_operand_tx #(.WIDTH(4), .CW(3)) dut4 (
        .clock(clock), .reset(reset), .load(load4), .hold(hold4),
        .a_in(a4), .b_in(b4), .ready(ready4), .shift_cont(sc4),
        .s_input_A(sa4), .s_input(sb4), .done(done4)
    );

    serial_operand_tx #(.WIDTH(8), .CW(3)) dut8 (
        .clock(clock), .reset(reset), .load(load8), .hold(hold8),
        .a_in(a8), .b_in(b8), .ready(ready8), .shift_cont(sc8),
        .s_input_A(sa8), .s_input(sb8), .done(done8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(string tag, logic obs, logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic bit_of(logic [7:0] v, int i);
        logic [7:0] t;
        t = v >> i;
        return t[0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0;
            aop[i]  = '0;
            bop[i]  = '0;
            idx[i]  = 0;
            sc[i]   = 1'b0;
        end
    endtask

    task automatic model_step(int i, logic ld, logic hd,
                              logic [7:0] a, logic [7:0] b);
        case (mode[i])
            0: if (ld) begin
                aop[i]  = a;
                bop[i]  = b;
                idx[i]  = 0;
                mode[i] = 1;
                sc[i]   = 1'b1;
            end
            1: if (!hd) begin
                idx[i]++;
                if (idx[i] == wid[i]) begin
                    mode[i] = 2;
                    sc[i]   = 1'b0;
                end else begin
                    sc[i] = 1'b1;
                end
            end else begin
                sc[i] = 1'b0;
            end
            default: mode[i] = 0;
        endcase
    endtask

    task automatic check_all();
        check("ready4", ready4, mode[0] == 0);
        check("shift_cont4", sc4, sc[0]);
        check("s_input_A4", sa4, bit_of(aop[0], idx[0]));
        check("s_input4", sb4, bit_of(bop[0], idx[0]));
        check("done4", done4, mode[0] == 2);
        check("ready8", ready8, mode[1] == 0);
        check("shift_cont8", sc8, sc[1]);
        check("s_input_A8", sa8, bit_of(aop[1], idx[1]));
        check("s_input8", sb8, bit_of(bop[1], idx[1]));
        check("done8", done8, mode[1] == 2);
    endtask

    task automatic clr();
        col_a4 = '0;
        col_b4 = '0;
        col_a8 = '0;
        n4 = 0;
        n8 = 0;
        d4 = 0;
        d8 = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(0, load4, hold4, {4'd0, a4}, {4'd0, b4});
        model_step(1, load8, hold8, a8, b8);
        #1;
        check_all();
        if (sc4 && n4 < 32) begin
            col_a4[n4] = sa4;
            col_b4[n4] = sb4;
            n4++;
        end
        if (sc8 && n8 < 32) begin
            col_a8[n8] = sa8;
            n8++;
        end
        if (done4) d4++;
        if (done8) d8++;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        wid[0] = 4;
        wid[1] = 8;
        reset = 1'b0;
        load4 = 1'b0; hold4 = 1'b0; a4 = '0; b4 = '0;
        load8 = 1'b0; hold8 = 1'b0; a8 = '0; b8 = '0;
        model_reset();
        clr();
        #2;
        check_all();
        #5 reset = 1'b1;
        ticks(2);

        // 1: basic transfer
        clr();
        a4 = 4'b0101; b4 = 4'b0011; load4 = 1'b1;
        tick();
        load4 = 1'b0;
        ticks(7);
        check_int("t1_bits", n4, 4);
        check_int("t1_a", int'(col_a4[3:0]), 4'b0101);
        check_int("t1_b", int'(col_b4[3:0]), 4'b0011);
        check_int("t1_done", d4, 1);

        // 2: hold after the second bit
        clr();
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        tick();
        hold4 = 1'b1;
        ticks(2);
        hold4 = 1'b0;
        ticks(7);
        check_int("t2_bits", n4, 4);
        check_int("t2_a", int'(col_a4[3:0]), 4'b0101);
        check_int("t2_b", int'(col_b4[3:0]), 4'b0011);
        check_int("t2_done", d4, 1);

        // 3: load while busy is ignored
        clr();
        load4 = 1'b1;
        tick();
        tick();
        a4 = 4'b1111;
        ticks(2);
        load4 = 1'b0;
        ticks(5);
        check_int("t3_a", int'(col_a4[3:0]), 4'b0101);
        check_int("t3_bits", n4, 4);

        // 4: async reset mid-transfer
        clr();
        a4 = 4'b0101; load4 = 1'b1;
        tick();
        load4 = 1'b0;
        ticks(2);
        #3 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 reset = 1'b1;
        tick();
        check_int("t4_nodone", d4, 0);
        clr();
        a4 = 4'b1000; b4 = 4'b0001; load4 = 1'b1;
        tick();
        load4 = 1'b0;
        ticks(7);
        check_int("t4_a", int'(col_a4[3:0]), 4'b1000);
        check_int("t4_b", int'(col_b4[3:0]), 4'b0001);

        // 5: back-to-back loads, period WIDTH+2
        clr();
        a4 = 4'b1001; b4 = 4'b0110; load4 = 1'b1;
        ticks(18);
        load4 = 1'b0;
        check_int("t5_done", d4, 3);
        check_int("t5_bits", n4, 12);
        check_int("t5_a", int'(col_a4[11:0]), 12'h999);
        check_int("t5_b", int'(col_b4[11:0]), 12'h666);
        ticks(8);

        // 6: WIDTH=8 instance
        clr();
        a8 = 8'hA5; b8 = 8'($urandom); load8 = 1'b1;
        tick();
        load8 = 1'b0;
        ticks(11);
        check_int("t6_bits", n8, 8);
        check_int("t6_a", int'(col_a8[7:0]), 8'hA5);
        check_int("t6_done", d8, 1);

        // random traffic on both instances
        for (int i = 0; i < 300; i++) begin
            load4 = ($urandom_range(0, 3) == 0);
            hold4 = ($urandom_range(0, 3) == 0);
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            load8 = ($urandom_range(0, 3) == 0);
            hold8 = ($urandom_range(0, 3) == 0);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
